// File: rtl/pc_sequencer_pkg.sv
// Shared types for the next-PC sequencer: FSM state encoding, next-PC source
// selector, and the instruction-size shift helper.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SRC_HOLD = 3'd0,
        SRC_SEQ  = 3'd1,
        SRC_BR   = 3'd2,
        SRC_J    = 3'd3,
        SRC_JR   = 3'd4
    } src_e;

    localparam int unsigned DEF_INSTR_BYTES = 4;
    localparam int unsigned S_DEF           = $clog2(DEF_INSTR_BYTES);

    // Byte-offset bits below the instruction index.
    function automatic int unsigned instr_shift(input int unsigned bytes);
        return $clog2(bytes);
    endfunction

    function automatic logic is_redirect(input src_e src);
        return (src == SRC_BR) || (src == SRC_J) || (src == SRC_JR);
    endfunction

endpackage

// File: rtl/pc_src_select.sv
// Combinational next-PC priority encoder and WIDTH-generic source mux.
// jumpReg > jump > branch > sequential > hold; nothing redirects during BOOT.
module pc_src_select
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned INSTR_BYTES = 4,
    parameter int unsigned JUMP_TGT_W  = 26
) (
    input  state_e                  state,
    input  logic [WIDTH-1:0]        pc,
    input  logic [WIDTH-1:0]        pc_plus,
    input  logic                    handshake,
    input  logic                    branch_taken,
    input  logic [WIDTH-1:0]        branch_target,
    input  logic                    jump,
    input  logic [JUMP_TGT_W-1:0]   jump_index,
    input  logic                    jump_reg,
    input  logic [WIDTH-1:0]        jump_reg_target,
    output logic [WIDTH-1:0]        next_pc,
    output src_e                    src,
    output logic                    misaligned
);

    localparam int unsigned      S          = instr_shift(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
    // Bits replaced by the J-type index plus the byte offset below it.
    localparam logic [WIDTH-1:0] LOW_MASK   = (WIDTH'(1) << (JUMP_TGT_W + S)) - WIDTH'(1);

    logic [WIDTH-1:0] jump_tgt;
    logic             jr_bad;

    assign jump_tgt = (pc_plus & ~LOW_MASK) | (WIDTH'(jump_index) << S);
    assign jr_bad   = |(jump_reg_target & ALIGN_MASK);

    always_comb begin
        src        = SRC_HOLD;
        misaligned = 1'b0;
        if (state != BOOT) begin
            if (jump_reg) begin
                if (jr_bad) begin
                    misaligned = 1'b1;
                end else begin
                    src = SRC_JR;
                end
            end else if (jump) begin
                src = SRC_J;
            end else if (branch_taken) begin
                src = SRC_BR;
            end else if ((state == RUN) && handshake) begin
                src = SRC_SEQ;
            end
        end
    end

    always_comb begin
        next_pc = pc;
        case (src)
            SRC_SEQ: next_pc = pc_plus;
            SRC_BR:  next_pc = branch_target;
            SRC_J:   next_pc = jump_tgt;
            SRC_JR:  next_pc = jump_reg_target;
            default: next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Front-of-fetch PC sequencer: registered PC, BOOT/RUN/HALTED control,
// fetch handshake and one-cycle redirect / alignment-trap pulses.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      INSTR_BYTES  = DEF_INSTR_BYTES,
    parameter int unsigned      JUMP_TGT_W   = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetchReady,
    output logic                  fetchValid,
    output logic [WIDTH-1:0]      fetchAddr,
    output logic [WIDTH-1:0]      pcPlusFour,
    input  logic                  branchTaken,
    input  logic [WIDTH-1:0]      branchTarget,
    input  logic                  jump,
    input  logic [JUMP_TGT_W-1:0] jumpIndex,
    input  logic                  jumpReg,
    input  logic [WIDTH-1:0]      jumpRegTarget,
    input  logic                  halt,
    input  logic                  resume,
    output logic                  redirected,
    output logic                  alignErr,
    output logic                  halted
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             redirected_q, redirected_d;
    logic             align_err_q, align_err_d;

    logic [WIDTH-1:0] next_pc;
    src_e             src;
    logic             misaligned;

    assign pcPlusFour = pc_q + WIDTH'(INSTR_BYTES);
    assign fetchAddr  = pc_q;
    assign fetchValid = (state_q == RUN);
    assign halted     = (state_q == HALTED);
    assign redirected = redirected_q;
    assign alignErr   = align_err_q;

    pc_src_select #(
        .WIDTH       (WIDTH),
        .INSTR_BYTES (INSTR_BYTES),
        .JUMP_TGT_W  (JUMP_TGT_W)
    ) u_src_select (
        .state           (state_q),
        .pc              (pc_q),
        .pc_plus         (pcPlusFour),
        .handshake       (fetchValid && fetchReady),
        .branch_taken    (branchTaken),
        .branch_target   (branchTarget),
        .jump            (jump),
        .jump_index      (jumpIndex),
        .jump_reg        (jumpReg),
        .jump_reg_target (jumpRegTarget),
        .next_pc         (next_pc),
        .src             (src),
        .misaligned      (misaligned)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = next_pc;
        redirected_d = is_redirect(src);
        align_err_d  = misaligned;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (misaligned || halt) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                // halt held alongside resume keeps the core parked
                if (!misaligned && resume && !halt) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            redirected_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redirected_q <= redirected_d;
            align_err_q  <= align_err_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: driver queues the expected post-edge outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        fetchReady;
    logic        fetchValid;
    logic [31:0] fetchAddr;
    logic [31:0] pcPlusFour;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [25:0] jumpIndex;
    logic        jumpReg;
    logic [31:0] jumpRegTarget;
    logic        halt;
    logic        resume;
    logic        redirected;
    logic        alignErr;
    logic        halted;

    pc_sequencer #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0),
        .INSTR_BYTES  (4),
        .JUMP_TGT_W   (26)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetchReady    (fetchReady),
        .fetchValid    (fetchValid),
        .fetchAddr     (fetchAddr),
        .pcPlusFour    (pcPlusFour),
        .branchTaken   (branchTaken),
        .branchTarget  (branchTarget),
        .jump          (jump),
        .jumpIndex     (jumpIndex),
        .jumpReg       (jumpReg),
        .jumpRegTarget (jumpRegTarget),
        .halt          (halt),
        .resume        (resume),
        .redirected    (redirected),
        .alignErr      (alignErr),
        .halted        (halted)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic        fv;
        logic [31:0] addr;
        logic        rd;
        logic        ae;
        logic        hl;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc   = 0;
    int   vecs  = 0;
    int   errs  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every entry is due on the negedge of its target cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            vecs++;
            if (e.cyc != cyc || fetchValid !== e.fv || fetchAddr !== e.addr ||
                pcPlusFour !== e.addr + 32'd4 || redirected !== e.rd ||
                alignErr !== e.ae || halted !== e.hl) begin
                errs++;
                $display("FAIL %s: got v=%0b addr=%h p4=%h rd=%0b ae=%0b hl=%0b cyc=%0d, want v=%0b addr=%h p4=%h rd=%0b ae=%0b hl=%0b cyc=%0d",
                         e.name, fetchValid, fetchAddr, pcPlusFour, redirected, alignErr, halted, cyc,
                         e.fv, e.addr, e.addr + 32'd4, e.rd, e.ae, e.hl, e.cyc);
            end
        end
    end

    // Queue expected outputs after the coming edge, take the edge, drop strobes.
    task automatic step(input string nm, input logic fv, input logic [31:0] addr,
                        input logic rd, input logic ae, input logic hl);
        exp_t x;
        x.cyc  = cyc + 1;
        x.name = nm;
        x.fv   = fv;
        x.addr = addr;
        x.rd   = rd;
        x.ae   = ae;
        x.hl   = hl;
        sb.push_back(x);
        @(posedge clk);
        #1;
        fetchReady  = 1'b0;
        branchTaken = 1'b0;
        jump        = 1'b0;
        jumpReg     = 1'b0;
        halt        = 1'b0;
        resume      = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        fetchReady    = 1'b0;
        branchTaken   = 1'b0;
        branchTarget  = '0;
        jump          = 1'b0;
        jumpIndex     = '0;
        jumpReg       = 1'b0;
        jumpRegTarget = '0;
        halt          = 1'b0;
        resume        = 1'b0;
        @(posedge clk);
        #1;
        step("reset0", 0, 32'h0, 0, 0, 0);
        step("reset1_boot", 0, 32'h0, 0, 0, 0);

        reset = 1'b0;
        fetchReady = 1'b1; branchTaken = 1'b1; branchTarget = 32'h500;
        step("boot_ignore", 1, 32'h0, 0, 0, 0);
        fetchReady = 1'b1; step("seq4", 1, 32'h4, 0, 0, 0);
        fetchReady = 1'b1; step("seq8", 1, 32'h8, 0, 0, 0);
        fetchReady = 1'b1; step("seqC", 1, 32'hC, 0, 0, 0);
        fetchReady = 1'b1; step("seq10", 1, 32'h10, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("stall", 1, 32'h10, 0, 0, 0);

        branchTaken = 1'b1; branchTarget = 32'h100;
        step("br100", 1, 32'h100, 1, 0, 0);
        branchTaken = 1'b1; branchTarget = 32'h200; jump = 1'b1; jumpIndex = 26'h40; fetchReady = 1'b1;
        step("j_over_br", 1, 32'h100, 1, 0, 0);
        step("idle_after_j", 1, 32'h100, 0, 0, 0);
        branchTaken = 1'b1; branchTarget = 32'h200; jump = 1'b1; jumpIndex = 26'h40;
        jumpReg = 1'b1; jumpRegTarget = 32'h300; fetchReady = 1'b1;
        step("jr_over_j", 1, 32'h300, 1, 0, 0);
        step("idle_after_jr", 1, 32'h300, 0, 0, 0);

        branchTaken = 1'b1; branchTarget = 32'h40;
        step("br40", 1, 32'h40, 1, 0, 0);
        jumpReg = 1'b1; jumpRegTarget = 32'h302; fetchReady = 1'b1;
        step("jr_misalign", 0, 32'h40, 0, 1, 1);
        fetchReady = 1'b1;
        step("halted_hold", 0, 32'h40, 0, 0, 1);
        resume = 1'b1;
        step("resume", 1, 32'h40, 0, 0, 0);
        resume = 1'b1; fetchReady = 1'b1;
        step("resume_in_run", 1, 32'h44, 0, 0, 0);

        branchTaken = 1'b1; branchTarget = 32'h12345670;
        step("br_hi", 1, 32'h12345670, 1, 0, 0);
        jump = 1'b1; jumpIndex = 26'h10;
        step("j_upper_bits", 1, 32'h10000040, 1, 0, 0);
        branchTaken = 1'b1; branchTarget = 32'hFFFFFFFC;
        step("br_top", 1, 32'hFFFFFFFC, 1, 0, 0);
        fetchReady = 1'b1;
        step("wrap", 1, 32'h0, 0, 0, 0);

        halt = 1'b1; fetchReady = 1'b1;
        step("halt_seq", 0, 32'h4, 0, 0, 1);
        branchTaken = 1'b1; branchTarget = 32'h800;
        step("br_halted", 0, 32'h800, 1, 0, 1);
        halt = 1'b1; resume = 1'b1;
        step("halt_and_resume", 0, 32'h800, 0, 0, 1);
        resume = 1'b1;
        step("resume2", 1, 32'h800, 0, 0, 0);
        fetchReady = 1'b1;
        step("seq804", 1, 32'h804, 0, 0, 0);

        reset = 1'b1; fetchReady = 1'b1; branchTaken = 1'b1; branchTarget = 32'h900;
        step("reset_mid_run", 0, 32'h0, 0, 0, 0);
        reset = 1'b0;
        step("reboot_run", 1, 32'h0, 0, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d entries still queued, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
